// File: rtl/tube_pkg.sv
// Shared definitions for the tube access controller: FSM state encoding
// and legal ranges for the timing parameters.
package tube_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    DONE    = 3'd4,
    RELEASE = 3'd5
  } tube_state_e;

  localparam int unsigned CYC_MIN     = 1;
  localparam int unsigned CYC_MAX     = 15;
  localparam int unsigned RST_CYC_MIN = 1;
  localparam int unsigned RST_CYC_MAX = 255;

  function automatic int unsigned clamp(input int unsigned v,
                                        input int unsigned lo,
                                        input int unsigned hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/tube_access_ctrl_if.sv
// Host-side request/response bus of the tube access controller.
interface tube_access_ctrl_if;
  logic       req;
  logic       rnw;
  logic [2:0] adr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       wait_b;
  logic       ack;

  modport master (output req, rnw, adr, wdata, input rdata, wait_b, ack);
  modport slave  (input req, rnw, adr, wdata, output rdata, wait_b, ack);
endinterface

// File: rtl/tube_rst_stretch.sv
// Holds the tube reset low for RST_CYC clocks after the system reset releases.
module tube_rst_stretch #(
  parameter int unsigned RST_CYC = 16
) (
  input  logic clk_i,
  input  logic reset_b_i,
  output logic tube_rst_b_o
);

  localparam logic [7:0] LAST = 8'(RST_CYC - 1);

  logic [7:0] cnt_q;
  logic       done_q;

  always_ff @(posedge clk_i or negedge reset_b_i) begin
    if (!reset_b_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      if (cnt_q == LAST) done_q <= 1'b1;
      else               cnt_q  <= cnt_q + 8'd1;
    end
  end

  assign tube_rst_b_o = done_q;

endmodule

// File: rtl/tube_access_ctrl.sv
// Tube bus access sequencer: SETUP -> STROBE -> HOLD -> DONE per host request.
// Optional reset stretch on tube_rst_b enabled by TUBE_RST_STRETCH_EN.
module tube_access_ctrl
  import tube_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PHI2_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned RST_CYC   = 16
) (
  input  logic                     clk,
  input  logic                     reset_b,
  tube_access_ctrl_if.slave        host,
  output logic [2:0]               tube_adr,
  output logic                     tube_rnw_b,
  output logic                     tube_phi2,
  output logic                     tube_cs_b,
  output logic                     tube_rst_b,
  input  logic [7:0]               tube_din,
  output logic [7:0]               tube_dout,
  output logic                     tube_doe
);

  // Phase counter reload values: a state lasting N clocks loads N-1.
  localparam logic [3:0] SETUP_LD = 4'(clamp(SETUP_CYC, CYC_MIN, CYC_MAX) - 1);
  localparam logic [3:0] PHI2_LD  = 4'(clamp(PHI2_CYC,  CYC_MIN, CYC_MAX) - 1);
  localparam logic [3:0] HOLD_LD  = 4'(clamp(HOLD_CYC,  CYC_MIN, CYC_MAX) - 1);

  tube_state_e state_q;
  logic [3:0]  cnt_q;
  logic        ready;
  logic [2:0]  adr_q;
  logic        rnw_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        cs_b_q;
  logic        phi2_q;
  logic        doe_q;
  logic        ack_q;

`ifdef TUBE_RST_STRETCH_EN
  tube_rst_stretch #(
    .RST_CYC (clamp(RST_CYC, RST_CYC_MIN, RST_CYC_MAX))
  ) u_rst_stretch (
    .clk_i        (clk),
    .reset_b_i    (reset_b),
    .tube_rst_b_o (tube_rst_b)
  );
  assign ready = tube_rst_b;
`else
  assign tube_rst_b = reset_b;
  assign ready      = reset_b;
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      rnw_q   <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
      cs_b_q  <= 1'b1;
      phi2_q  <= 1'b0;
      doe_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: if (host.req && ready) begin
          state_q <= SETUP;
          cnt_q   <= SETUP_LD;
          adr_q   <= host.adr;
          rnw_q   <= host.rnw;
          wdata_q <= host.wdata;
          cs_b_q  <= 1'b0;
          doe_q   <= !host.rnw;
        end
        SETUP: if (cnt_q == '0) begin
          state_q <= STROBE;
          cnt_q   <= PHI2_LD;
          phi2_q  <= 1'b1;
        end else cnt_q <= cnt_q - 4'd1;
        STROBE: if (cnt_q == '0) begin
          state_q <= HOLD;
          cnt_q   <= HOLD_LD;
          phi2_q  <= 1'b0;
          if (rnw_q) rdata_q <= tube_din;
        end else cnt_q <= cnt_q - 4'd1;
        HOLD: if (cnt_q == '0) begin
          state_q <= DONE;
          cnt_q   <= '0;
          cs_b_q  <= 1'b1;
          doe_q   <= 1'b0;
          ack_q   <= 1'b1;
        end else cnt_q <= cnt_q - 4'd1;
        DONE: begin
          state_q <= RELEASE;
          cnt_q   <= '0;
        end
        RELEASE: if (!host.req) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // wait_b drops in the same cycle req rises so the host stalls immediately.
  assign host.wait_b = !((state_q == IDLE && host.req && ready) ||
                         state_q == SETUP || state_q == STROBE || state_q == HOLD);
  assign host.ack    = ack_q;
  assign host.rdata  = rdata_q;
  assign tube_adr    = adr_q;
  assign tube_rnw_b  = rnw_q;
  assign tube_cs_b   = cs_b_q;
  assign tube_phi2   = phi2_q;
  assign tube_doe    = doe_q;
  assign tube_dout   = wdata_q;

endmodule
